// File: rtl/ddr3_clk_seq.sv
// ddr3_clk_seq: bring-up sequencer for the ECP3 DDR3 clock subsystem (lock wait, DLL update,
// ECLKSYNC restart, datapath reset, PLL phase search). DDR3_CLK_SEQ_MARGIN_EN adds a DONE-state phase offset.
module ddr3_clk_seq #(
  parameter int LOCK_WAIT     = 64,
  parameter int UPD_CYCLES    = 16,
  parameter int STOP_CYCLES   = 4,
  parameter int RST_CYCLES    = 8,
  parameter int SETTLE_CYCLES = 160,
  parameter int UPD_PERIOD    = 4096
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       dll_lock,
  input  logic [1:0] align_status,
`ifdef DDR3_CLK_SEQ_MARGIN_EN
  input  logic [3:0] margin_code,
`endif
  output logic [3:0] phase,
  output logic       stop,
  output logic       reset_datapath,
  output logic       uddcntln,
  output logic       good,
  output logic       err
);

  localparam logic [15:0] LW_LD     = 16'(LOCK_WAIT - 1);
  localparam logic [15:0] UPD_LD    = 16'(UPD_CYCLES - 1);
  localparam logic [15:0] STOP_LD   = 16'(STOP_CYCLES - 1);
  localparam logic [15:0] RST_LD    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] PER_LD    = (UPD_PERIOD == 0) ? 16'd0 : 16'(UPD_PERIOD - 1);

  typedef enum logic [3:0] {
    S_WAIT_LOCK, S_DLL_UPD, S_STOP, S_RST_DP, S_SETTLE,
    S_CHECK, S_DONE, S_DONE_UPD, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [3:0]  phase_q, phase_nxt;
  logic [3:0]  tries, tries_nxt;
  logic        pll_lock_p0, pll_lock_p1, dll_lock_p0, dll_lock_p1;
  logic        lk;

  assign lk = pll_lock_p1 & dll_lock_p1;

  always_ff @(posedge sclk) begin
    if (reset) begin
      state       <= S_WAIT_LOCK;
      timer       <= '0;
      phase_q     <= '0;
      tries       <= '0;
      pll_lock_p0 <= 1'b0;
      pll_lock_p1 <= 1'b0;
      dll_lock_p0 <= 1'b0;
      dll_lock_p1 <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      phase_q     <= phase_nxt;
      tries       <= tries_nxt;
      // lock synchronizer stage p0 -> p1
      pll_lock_p0 <= pll_lock;
      pll_lock_p1 <= pll_lock_p0;
      dll_lock_p0 <= dll_lock;
      dll_lock_p1 <= dll_lock_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = (timer == '0) ? timer : timer - 16'd1;
    phase_nxt = phase_q;
    tries_nxt = tries;
    if (state != S_WAIT_LOCK && state != S_ERR && !lk) begin
      // lock loss restarts the search from the current phase
      state_nxt = S_WAIT_LOCK;
      timer_nxt = LW_LD;
      tries_nxt = '0;
    end else begin
      case (state)
        S_WAIT_LOCK: begin
          if (!lk) timer_nxt = LW_LD;
          else if (timer == '0) begin
            state_nxt = S_DLL_UPD;
            timer_nxt = UPD_LD;
          end
        end
        S_DLL_UPD: if (timer == '0) begin state_nxt = S_STOP;   timer_nxt = STOP_LD;   end
        S_STOP:    if (timer == '0) begin state_nxt = S_RST_DP; timer_nxt = RST_LD;    end
        S_RST_DP:  if (timer == '0) begin state_nxt = S_SETTLE; timer_nxt = SETTLE_LD; end
        S_SETTLE:  if (timer == '0) state_nxt = S_CHECK;
        S_CHECK: begin
          if (align_status == 2'b00) begin
            state_nxt = S_DONE;
            timer_nxt = PER_LD;
          end else if (tries == 4'd15) begin
            state_nxt = S_ERR;
          end else begin
            phase_nxt = phase_q + 4'd1;
            tries_nxt = tries + 4'd1;
            state_nxt = S_STOP;
            timer_nxt = STOP_LD;
          end
        end
        S_DONE: begin
          if (UPD_PERIOD != 0 && timer == '0) begin
            state_nxt = S_DONE_UPD;
            timer_nxt = UPD_LD;
          end
        end
        S_DONE_UPD: if (timer == '0) begin state_nxt = S_DONE; timer_nxt = PER_LD; end
        default: state_nxt = state;
      endcase
    end
  end

  assign stop           = (state == S_STOP);
  assign reset_datapath = (state inside {S_WAIT_LOCK, S_DLL_UPD, S_STOP, S_RST_DP, S_ERR});
  assign uddcntln       = !(state inside {S_DLL_UPD, S_DONE_UPD});
  assign good           = (state inside {S_DONE, S_DONE_UPD});
  assign err            = (state == S_ERR);

`ifdef DDR3_CLK_SEQ_MARGIN_EN
  logic [3:0] margin_p0;

  always_ff @(posedge sclk) begin
    margin_p0 <= margin_code;
  end

  assign phase = phase_q + (good ? margin_p0 : 4'd0);
`else
  assign phase = phase_q;
`endif

endmodule

// File: tb/tb_ddr3_clk_seq.sv
// Scoreboard bench for ddr3_clk_seq: expected output-vector changes and their hold times are
// queued by the stimulus and checked by a monitor on every output change.
module tb_ddr3_clk_seq;
  logic       sclk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b1;
  logic       dll_lock = 1'b1;
  logic [1:0] align_status;
  logic [3:0] phase;
  logic       stop, reset_datapath, uddcntln, good, err;
`ifdef DDR3_CLK_SEQ_MARGIN_EN
  logic [3:0] margin_code = 4'd0;
`endif

  int mode = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    logic [8:0] vec;
    int         dur;
  } ev_t;
  ev_t exp_q[$];

  logic [8:0] cur;
  assign cur = {phase, stop, reset_datapath, uddcntln, good, err};

  always #5 sclk = ~sclk;

  ddr3_clk_seq dut (
    .sclk(sclk),
    .reset(reset),
    .pll_lock(pll_lock),
    .dll_lock(dll_lock),
    .align_status(align_status),
`ifdef DDR3_CLK_SEQ_MARGIN_EN
    .margin_code(margin_code),
`endif
    .phase(phase),
    .stop(stop),
    .reset_datapath(reset_datapath),
    .uddcntln(uddcntln),
    .good(good),
    .err(err)
  );

  // phase detector model: aligned at a chosen phase, or always/never aligned
  always_comb begin
    align_status = 2'b00;
    case (mode)
      0: align_status = 2'b00;
      1: align_status = (phase == 4'd5) ? 2'b00 : 2'b01;
      2: align_status = 2'b10;
      default: align_status = (phase == 4'd3) ? 2'b00 : 2'b01;
    endcase
  end

  task automatic push(input int ph, input bit s, input bit r, input bit u,
                      input bit g, input bit e, input int d);
    ev_t ev;
    ev.vec = {4'(ph), s, r, u, g, e};
    ev.dur = d;
    exp_q.push_back(ev);
  endtask

  task automatic startup(input int ph, input int d0);
    push(ph, 0, 1, 0, 0, 0, d0);
    push(ph, 1, 1, 1, 0, 0, 16);
    push(ph, 0, 1, 1, 0, 0, 4);
    push(ph, 0, 0, 1, 0, 0, 8);
  endtask

  task automatic step(input int ph);
    push(ph, 1, 1, 1, 0, 0, 161);
    push(ph, 0, 1, 1, 0, 0, 4);
    push(ph, 0, 0, 1, 0, 0, 8);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge sclk); #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d events pending after %0d cycles, want 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) begin @(posedge sclk); #1; end
    check("reset_state", cur, 9'b0000_0_1_1_0_0);
  endtask

  task automatic run_monitor();
    logic [8:0] prev;
    int cnt;
    ev_t e;
    prev = cur;
    cnt = 0;
    forever begin
      @(negedge sclk);
      if (reset) begin
        prev = cur;
        cnt = 0;
      end else begin
        cnt++;
        if (cur !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_change: got %h after %0d cycles, want no change", cur, cnt);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e.vec || (e.dur >= 0 && cnt != e.dur)) begin
              fails++;
              $display("FAIL event: got vec=%h dur=%0d, want vec=%h dur=%0d", cur, cnt, e.vec, e.dur);
            end
          end
          prev = cur;
          cnt = 0;
        end
      end
    end
  endtask

  initial begin
    fork
      run_monitor();
    join_none

    // immediate alignment at phase 0
    mode = 0;
    do_reset();
    startup(0, 67);
    push(0, 0, 0, 1, 1, 0, 161);
    reset = 1'b0;
    drain(400);

    // search steps 0 -> 5
    mode = 1;
    do_reset();
    startup(0, 67);
    for (int p = 1; p <= 5; p++) step(p);
    push(5, 0, 0, 1, 1, 0, 161);
    reset = 1'b0;
    drain(1500);

    // lock loss in DONE, relock resumes from phase 5, then periodic DLL updates
    push(5, 0, 1, 1, 0, 0, -1);
    startup(5, 66);
    push(5, 0, 0, 1, 1, 0, 161);
    push(5, 0, 0, 0, 1, 0, 4096);
    push(5, 0, 0, 1, 1, 0, 16);
    push(5, 0, 0, 0, 1, 0, 4096);
    push(5, 0, 0, 1, 1, 0, 16);
    pll_lock = 1'b0;
    @(posedge sclk); #1;
    @(posedge sclk); #1;
    check("good_before_sync", {8'd0, good}, 9'd1);
    @(posedge sclk); #1;
    check("good_after_loss", {8'd0, good}, 9'd0);
    pll_lock = 1'b1;
    drain(9000);

`ifdef DDR3_CLK_SEQ_MARGIN_EN
    mode = 3;
    do_reset();
    startup(0, 67);
    for (int p = 1; p <= 3; p++) step(p);
    push(3, 0, 0, 1, 1, 0, 161);
    reset = 1'b0;
    drain(1000);
    push(1, 0, 0, 1, 1, 0, -1);
    margin_code = 4'hE;
    drain(10);
    push(3, 0, 1, 1, 0, 0, -1);
    pll_lock = 1'b0;
    drain(10);
    pll_lock = 1'b1;
`endif

    // never aligned: full rotation then sticky error
    mode = 2;
    do_reset();
    startup(0, 67);
    for (int p = 1; p <= 15; p++) step(p);
    push(15, 0, 1, 1, 0, 1, 161);
    reset = 1'b0;
    drain(3500);
    repeat (1000) @(posedge sclk);
    #1;
    check("err_sticky", cur, 9'b1111_0_1_1_0_1);
    reset = 1'b1;
    @(posedge sclk); #1;
    check("reset_clears_err", cur, 9'b0000_0_1_1_0_0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ddr3_clk_seq.md
Name: ddr3_clk_seq

Overview:
- Sequencer for the ECP3 DDR3 clock subsystem: PLL, DQSDLLB, ECLKSYNCA and the eclk/sclk phase detector.
- After PLL and DLL lock, it freezes/updates the DLL, stops ECLKSYNC, pulses datapath reset and waits for the filtered align status.
- While misaligned it steps the PLL dynamic phase, giving up after a full rotation. Once aligned it keeps monitoring lock and periodically re-enables DLL code updates.

Parameters:
LOCK_WAIT, 64, sclk cycles both locks must be continuously high before sequencing
UPD_CYCLES, 16, sclk cycles uddcntln is held low per DLL update window
STOP_CYCLES, 4, sclk cycles stop is asserted per ECLKSYNC restart
RST_CYCLES, 8, sclk cycles reset_datapath is asserted per pulse
SETTLE_CYCLES, 160, sclk cycles waited after reset_datapath release before sampling align_status (covers 128-cycle filter)
UPD_PERIOD, 4096, sclk cycles between periodic DLL update windows in DONE; 0 disables

Ports:
sclk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high
pll_lock  in  1  PLL LOCK, asynchronous; double-flopped internally
dll_lock  in  1  DQSDLLB LOCK, asynchronous; double-flopped internally
align_status  in  2  filtered phase detector status; 2'b00 = aligned, any other value = misaligned
phase  out  4  PLL DPHASE[3:0]
stop  out  1  ECLKSYNCA STOP
reset_datapath  out  1  datapath reset to clk_stop/clk_phase logic
uddcntln  out  1  DQSDLLB update control; 0 = update allowed, 1 = code frozen
good  out  1  alignment achieved and locks held
err  out  1  sticky: full rotation tried without alignment

Behaviour:
- Reset values: phase=0, stop=0, reset_datapath=1, uddcntln=1, good=0, err=0, state=WAIT_LOCK, timer=0, tries=0.
- Timer: single 16-bit down counter, loaded on state entry; a state exits on the cycle the timer reads 0. Wait of N cycles means the output stays asserted exactly N sclk cycles.
- lk = synchronized pll_lock & dll_lock.
- WAIT_LOCK: reset_datapath=1, good=0. Timer reloads LOCK_WAIT whenever lk=0. Expiry with lk=1 -> DLL_UPD.
- DLL_UPD: uddcntln=0 for UPD_CYCLES -> STOP.
- STOP: stop=1, reset_datapath=1 for STOP_CYCLES -> RST_DP.
- RST_DP: stop=0, reset_datapath=1 for RST_CYCLES -> SETTLE.
- SETTLE: reset_datapath=0, SETTLE_CYCLES -> CHECK.
- CHECK (1 cycle):
  - align_status==2'b00 -> DONE, good=1 from next cycle.
  - Otherwise, if tries==15 -> ERR.
  - Otherwise phase<=phase+1 (mod 16, 15 wraps to 0), tries<=tries+1, -> STOP.
  - The new phase is visible in the STOP state's first cycle.
- DONE: good=1, reset_datapath=0, stop=0.
  - If UPD_PERIOD!=0, a period counter expiring drives uddcntln=0 for UPD_CYCLES, then reloads; good stays 1 during the window.
  - align_status is not re-checked in DONE.
- ERR: err=1 (sticky until reset), good=0, reset_datapath=1, stop=0, phase held. Left only by reset.
- Lock loss: lk=0 in any state other than WAIT_LOCK and ERR -> WAIT_LOCK next cycle.
  - good drops the same cycle the state changes.
  - uddcntln returns to 1.
  - phase is retained; tries is cleared, so the search restarts from the current phase.
- Simultaneous events: reset dominates everything. Lock loss dominates a CHECK decision and an update-window expiry.
- Total tries per search = 16 phases (initial + 15 steps).

Optional Feature:
- Macro DDR3_CLK_SEQ_MARGIN_EN.
- Defined:
  - Adds input margin_code[3:0].
  - In DONE, the phase output = search phase + margin_code (mod 16), updated one cycle after margin_code changes.
  - In all other states the offset is 0.
  - The stored search phase is unaffected.
- Undefined: port absent; phase = search phase always.

Test Plan:
- Reset, both locks high from cycle 0, align_status=2'b00 -> uddcntln low 16 cycles, stop high 4, reset_datapath released after 12 more, good=1 at CHECK+1, phase=0.
- align_status=2'b01 until phase=5, then 2'b00 -> phase steps 0->1->...->5 with one STOP/RST_DP/SETTLE cycle per step; good=1, err=0, phase=5.
- align_status stuck 2'b10 -> 16 CHECKs, phase ends at 15, err=1, good=0, reset_datapath=1; still err=1 1000 cycles later; reset clears it.
- In DONE with phase=5, drop pll_lock 3 cycles -> good=0 within sync latency; relock -> LOCK_WAIT=64 cycles then full sequence; search starts from phase=5.
- In DONE, UPD_PERIOD=4096 -> uddcntln low exactly 16 cycles every 4096+16 cycles; good stays 1.
- MARGIN_EN: aligned at phase=3, margin_code=4'hE -> phase=1 (wrap); lock loss -> phase output returns to 3.
